// File: rtl/somador_subtrator.sv
// Registered unsigned adder/subtractor with a WIDTH+1 bit result and status flags.
// Define SOMADOR_SATURACAO_EN to clamp a negative subtraction result to zero.
module somador_subtrator #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             select,
    output logic [WIDTH:0]   resul,
    output logic             valid,
    output logic             zero,
    output logic             borrow,
    output logic             carry
);

    logic             w_sub;
    logic [WIDTH:0]   w_a_ext;
    logic [WIDTH:0]   w_b_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_res;
    logic             w_borrow;
    logic             w_carry;

    logic [WIDTH:0]   r_resul;
    logic             r_valid;
    logic             r_zero;
    logic             r_borrow;
    logic             r_carry;

    // One adder serves both operations: a - b is a + ~b + 1 on zero-extended operands.
    assign w_sub    = ~select;
    assign w_a_ext  = {1'b0, a};
    assign w_b_ext  = {1'b0, b} ^ {(WIDTH+1){w_sub}};
    assign w_sum    = w_a_ext + w_b_ext + {{WIDTH{1'b0}}, w_sub};

    // With |a-b| < 2^WIDTH the top bit of the difference is set exactly when a < b.
    assign w_borrow = w_sub & w_sum[WIDTH];
    assign w_carry  = select & w_sum[WIDTH];

`ifdef SOMADOR_SATURACAO_EN
    assign w_res    = w_borrow ? '0 : w_sum;
`else
    assign w_res    = w_sum;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_resul  <= '0;
            r_valid  <= 1'b0;
            r_zero   <= 1'b1;
            r_borrow <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            r_valid <= enable;
            if (enable) begin
                r_resul  <= w_res;
                r_zero   <= (w_res == '0);
                r_borrow <= w_borrow;
                r_carry  <= w_carry;
            end
        end
    end

    assign resul  = r_resul;
    assign valid  = r_valid;
    assign zero   = r_zero;
    assign borrow = r_borrow;
    assign carry  = r_carry;

endmodule

// File: tb/tb_somador_subtrator.sv
// Directed scoreboard bench for somador_subtrator (WIDTH=4); honours SOMADOR_SATURACAO_EN.
module tb_somador_subtrator;

    localparam int W = 4;

    typedef struct packed {
        logic [W:0] r;
        logic       z;
        logic       bo;
        logic       c;
    } exp_t;

    logic         clock;
    logic         reset_n;
    logic         enable;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         select;
    logic [W:0]   resul;
    logic         valid;
    logic         zero;
    logic         borrow;
    logic         carry;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t last;

    somador_subtrator #(.WIDTH(W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (enable),
        .a       (a),
        .b       (b),
        .select  (select),
        .resul   (resul),
        .valid   (valid),
        .zero    (zero),
        .borrow  (borrow),
        .carry   (carry)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t model(input int ia, input int ib, input logic sel);
        exp_t e;
        int   r;
        logic [31:0] rv;
        if (sel) r = ia + ib;
        else     r = ia - ib;
        e.bo = !sel && (ia < ib);
        e.c  = sel && (r >= (1 << W));
`ifdef SOMADOR_SATURACAO_EN
        if (e.bo) r = 0;
`endif
        rv  = r;
        e.r = rv[W:0];
        e.z = (e.r == 0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_outputs(input string tag, input exp_t e);
        chk({tag, ".resul"},  32'(resul),  32'(e.r));
        chk({tag, ".zero"},   32'(zero),   32'(e.z));
        chk({tag, ".borrow"}, 32'(borrow), 32'(e.bo));
        chk({tag, ".carry"},  32'(carry),  32'(e.c));
    endtask

    // Drive on the falling edge, check 1 time unit after the next rising edge.
    task automatic step(input string tag, input logic en, input int ia, input int ib, input logic sel);
        @(negedge clock);
        enable = en;
        a      = W'(ia);
        b      = W'(ib);
        select = sel;
        if (en) q.push_back(model(ia, ib, sel));
        @(posedge clock);
        #1;
        chk({tag, ".valid"}, 32'(valid), 32'(en));
        if (en) begin
            if (q.size() == 0) begin
                chk({tag, ".queue"}, 32'd0, 32'd1);
            end else begin
                last = q.pop_front();
                chk_outputs(tag, last);
            end
        end else begin
            chk_outputs(tag, last);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        a       = '0;
        b       = '0;
        select  = 1'b1;
        last    = '{r: '0, z: 1'b1, bo: 1'b0, c: 1'b0};
        #12;
        chk("rst0.valid", 32'(valid), 32'd0);
        chk_outputs("rst0", last);
        @(negedge clock);
        reset_n = 1'b1;

        step("add0p0", 1'b1, 0, 0, 1'b1);
        step("add1p0", 1'b1, 1, 0, 1'b1);
        step("add1p2", 1'b1, 1, 2, 1'b1);
        step("add3p1", 1'b1, 3, 1, 1'b1);

        step("sub3m1", 1'b1, 3, 1, 1'b0);
        step("sub1m1", 1'b1, 1, 1, 1'b0);
        step("sub4m1", 1'b1, 4, 1, 1'b0);
        step("sub1m2", 1'b1, 1, 2, 1'b0);

        step("add15p15", 1'b1, 15, 15, 1'b1);
        step("sub0m15",  1'b1, 0, 15, 1'b0);
        step("sub15m0",  1'b1, 15, 0, 1'b0);

        step("hold_set", 1'b1, 3, 1, 1'b1);
        for (int i = 0; i < 3; i++) step("hold", 1'b0, 9, 9, 1'b1);

        step("tp0", 1'b1, 7, 8, 1'b1);
        step("tp1", 1'b1, 2, 9, 1'b0);
        step("tp2", 1'b1, 12, 5, 1'b0);
        step("tp3", 1'b1, 8, 8, 1'b1);
        step("tp4", 1'b1, 6, 6, 1'b0);
        step("tp_end", 1'b0, 0, 0, 1'b1);

        // Mid-cycle async reset with resul=7, an enabled operation pending.
        step("pre_rst", 1'b1, 3, 4, 1'b1);
        enable = 1'b1;
        a      = 4'd5;
        b      = 4'd5;
        #2;
        reset_n = 1'b0;
        #1;
        last = '{r: '0, z: 1'b1, bo: 1'b0, c: 1'b0};
        chk("rst1.valid", 32'(valid), 32'd0);
        chk_outputs("rst1", last);
        @(negedge clock);
        enable  = 1'b0;
        reset_n = 1'b1;
        step("post_rst_idle", 1'b0, 5, 5, 1'b1);
        step("post_rst_op",   1'b1, 2, 3, 1'b1);

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
